segre_mem_responder: RTL

- Memory-side responder for the cache-to-memory request protocol (cache_mem_req_t).
- Accepts one line-sized request at a time from the icache/dcache arbiter.
- Performs the line read or write on an internal line-organised array, models a fixed access latency, and returns a response routed to the originating cache by cache_id.
- Serves as the main-memory model for the Segre core and its testbenches.

---
 rtl/segre_mem_responder_if.sv | 41 ++++
 rtl/segre_mem_responder.sv | 79 +++++++
 2 files changed

// File: rtl/segre_mem_responder_if.sv
// Cache-to-memory request protocol: request struct plus the arbiter/responder bus.
package segre_mem_pkg;
  localparam int ADDR_SIZE            = 32;
  localparam int CACHE_LINE_SIZE_BITS = 128;
  localparam int M                    = $clog2(CACHE_LINE_SIZE_BITS / 8);

  typedef enum logic {ICACHE = 1'b0, DCACHE = 1'b1} cache_id_e;

  typedef struct packed {
    cache_id_e                       cache_id;
    logic                            rd;
    logic                            wr;
    logic [ADDR_SIZE-1:0]            addr;
    logic [CACHE_LINE_SIZE_BITS-1:0] cache_line;
  } cache_mem_req_t;
endpackage

interface segre_mem_responder_if;
  import segre_mem_pkg::*;

  logic                            req_valid_i;
  logic                            req_ready_o;
  cache_mem_req_t                  req_i;
  logic                            icache_rsp_valid_o;
  logic                            dcache_rsp_valid_o;
  logic                            rsp_wr_ack_o;
  logic [ADDR_SIZE-1:0]            rsp_addr_o;
  logic [CACHE_LINE_SIZE_BITS-1:0] rsp_line_o;

  modport master (
    output req_valid_i, req_i,
    input  req_ready_o, icache_rsp_valid_o, dcache_rsp_valid_o,
           rsp_wr_ack_o, rsp_addr_o, rsp_line_o
  );

  modport slave (
    input  req_valid_i, req_i,
    output req_ready_o, icache_rsp_valid_o, dcache_rsp_valid_o,
           rsp_wr_ack_o, rsp_addr_o, rsp_line_o
  );
endinterface

// File: rtl/segre_mem_responder.sv
// Main-memory model: one line request at a time, fixed latency, response
// routed back to the requesting cache.
module segre_mem_responder
  import segre_mem_pkg::*;
#(
  parameter  int LATENCY   = 4,
  parameter  int MEM_LINES = 256,
  localparam int IDX_BITS  = $clog2(MEM_LINES)
) (
  input  logic                  clk_i,
  input  logic                  rsn_i,
  segre_mem_responder_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

  state_e                          state, state_nxt;
  logic [7:0]                      cnt;
  cache_id_e                       rsp_id;
  logic                            rsp_wr;
  logic [ADDR_SIZE-1:0]            rsp_addr;
  logic [CACHE_LINE_SIZE_BITS-1:0] rsp_line;
  logic [CACHE_LINE_SIZE_BITS-1:0] mem [MEM_LINES];

  logic                 accept;
  logic [IDX_BITS-1:0]  idx;

  assign bus.req_ready_o = (state == IDLE);
  assign accept          = bus.req_valid_i && bus.req_ready_o;
  assign idx             = bus.req_i.addr[M+IDX_BITS-1:M];

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept && (bus.req_i.rd || bus.req_i.wr)) state_nxt = BUSY;
      BUSY: if (cnt == 8'd0) state_nxt = RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      cnt      <= '0;
      rsp_id   <= ICACHE;
      rsp_wr   <= 1'b0;
      rsp_addr <= '0;
      rsp_line <= '0;
    end else if (accept) begin
      cnt      <= CNT_INIT;
      rsp_id   <= bus.req_i.cache_id;
      rsp_wr   <= bus.req_i.wr;
      rsp_addr <= {bus.req_i.addr[ADDR_SIZE-1:M], {M{1'b0}}};
      // A combined rd+wr returns the line being written, not the old contents.
      rsp_line <= bus.req_i.wr ? bus.req_i.cache_line : mem[idx];
    end else if (state == BUSY && cnt != 8'd0) begin
      cnt <= cnt - 8'd1;
    end
  end

  // The array is deliberately not reset so contents survive a mid-run reset.
  always_ff @(posedge clk_i) begin
    if (accept && bus.req_i.wr) mem[idx] <= bus.req_i.cache_line;
  end

  assign bus.icache_rsp_valid_o = (state == RESP) && (rsp_id == ICACHE);
  assign bus.dcache_rsp_valid_o = (state == RESP) && (rsp_id == DCACHE);
  assign bus.rsp_wr_ack_o       = rsp_wr;
  assign bus.rsp_addr_o         = rsp_addr;
  assign bus.rsp_line_o         = rsp_line;

endmodule
